// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state encoding, default send-start
// timeout, board baud/clock constants (also used by rx/xmit) and the
// round-robin pointer advance helper.
package uart_pkg;

    // Arbiter FSM states, 3-bit legacy-compatible encoding
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SEND       = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_HOLD       = 3'd4;

    // Cycles to wait for xmit busy before assuming the byte is in flight
    localparam int START_TIMEOUT_DEF = 32'sd4;

    // Board clocking shared with rx/xmit
    localparam int UART_BAUD     = 32'sd57600;
    localparam int UART_CLK_HZ   = 32'sd12_000_000;
    localparam int UART_BAUD_DIV = UART_CLK_HZ / UART_BAUD;

    // Next round-robin start position after requester idx releases
    function automatic int rr_next(input int idx, input int n);
        if (idx >= n - 32'sd1) begin
            return 32'sd0;
        end else begin
            return idx + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for uart_tx_arbiter.
//   req, req_data, req_lock : requester byte lanes (lane i = bits 8i+7:8i)
//   req_ack, grant          : per-requester take pulse and current owner
//   tx_data, tx_send        : byte and strobe towards xmit
//   tx_busy                 : xmit busy
//   active                  : arbiter not idle
// master = requesters/xmit side, slave = arbiter side.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_busy;
    logic           active;

    modport master (
        output req, req_data, req_lock, tx_busy,
        input  req_ack, grant, tx_data, tx_send, active
    );

    modport slave (
        input  req, req_data, req_lock, tx_busy,
        output req_ack, grant, tx_data, tx_send, active
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational N-way rotating-priority picker.
//   req     : request vector
//   ptr     : index holding highest priority this round
//   win     : one-hot winner (0 when no request)
//   win_idx : binary index of the winner (0 when no request)
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] win_idx
);

    logic          found_s;
    logic [PW-1:0] pos_s;

    // Scan ptr, ptr+1, ... wrapping, and take the first requester found
    always_comb begin
        win     = '0;
        win_idx = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = PW'((int'(ptr) + k) % N);
            if (!found_s && req[pos_s]) begin
                found_s      = 1'b1;
                win[pos_s]   = 1'b1;
                win_idx      = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N byte requesters with
// round-robin arbitration and per-requester message lock.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : requester lanes, acks/grant, xmit data/send/busy, active
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N             = 4,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int PW = $clog2(N);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

    logic [2:0]    state_r,   state_s;
    logic [PW-1:0] ptr_r,     ptr_s;
    logic [PW-1:0] gidx_r,    gidx_s;
    logic [N-1:0]  grant_r,   grant_s;
    logic [7:0]    tx_data_r, tx_data_s;
    logic          tx_send_r, tx_send_s;
    logic [N-1:0]  req_ack_r, req_ack_s;
    logic          active_r,  active_s;
    logic [TW-1:0] to_cnt_r,  to_cnt_s;

    logic [N-1:0]  pick_win_s;
    logic [PW-1:0] pick_idx_s;
    logic [7:0]    pick_byte_s;
    logic [7:0]    g_byte_s;
    logic          g_req_s;
    logic          g_lock_s;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_r),
        .win     (pick_win_s),
        .win_idx (pick_idx_s)
    );

    // Only the arbitration winner's lane or the owner's lane is ever sampled
    assign pick_byte_s = bus.req_data[{pick_idx_s, 3'b000} +: 8];
    assign g_byte_s    = bus.req_data[{gidx_r, 3'b000} +: 8];
    assign g_req_s     = bus.req[gidx_r];
    assign g_lock_s    = bus.req_lock[gidx_r];

    // Next-state logic; send strobe and ack are armed on entry to SEND
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        gidx_s    = gidx_r;
        grant_s   = grant_r;
        tx_data_s = tx_data_r;
        tx_send_s = 1'b0;
        req_ack_s = '0;
        to_cnt_s  = to_cnt_r;
        case (state_r)
            ST_IDLE: begin
                grant_s = '0;
                if (|bus.req) begin
                    state_s   = ST_SEND;
                    grant_s   = pick_win_s;
                    gidx_s    = pick_idx_s;
                    tx_data_s = pick_byte_s;
                    tx_send_s = 1'b1;
                    req_ack_s = pick_win_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_s  = ST_WAIT_START;
                to_cnt_s = '0;
            end
            ST_WAIT_START: begin
                // A silent xmit is assumed to have taken the byte after the timeout
                if (bus.tx_busy || (to_cnt_r == TO_LAST)) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    to_cnt_s = to_cnt_r + TW'(1'b1);
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else if (g_lock_s && g_req_s) begin
                    state_s   = ST_SEND;
                    tx_data_s = g_byte_s;
                    tx_send_s = 1'b1;
                    req_ack_s = grant_r;
                end else if (g_lock_s) begin
                    state_s = ST_HOLD;
                end else begin
                    // Release: the pointer only moves here, never per byte
                    ptr_s   = PW'(rr_next(int'(gidx_r), N));
                    grant_s = '0;
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (g_req_s) begin
                    state_s   = ST_SEND;
                    tx_data_s = g_byte_s;
                    tx_send_s = 1'b1;
                    req_ack_s = grant_r;
                end else if (!g_lock_s) begin
                    ptr_s   = PW'(rr_next(int'(gidx_r), N));
                    grant_s = '0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
        active_s = (state_s != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            gidx_r    <= '0;
            grant_r   <= '0;
            tx_data_r <= 8'h00;
            tx_send_r <= 1'b0;
            req_ack_r <= '0;
            active_r  <= 1'b0;
            to_cnt_r  <= '0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            gidx_r    <= gidx_s;
            grant_r   <= grant_s;
            tx_data_r <= tx_data_s;
            tx_send_r <= tx_send_s;
            req_ack_r <= req_ack_s;
            active_r  <= active_s;
            to_cnt_r  <= to_cnt_s;
        end
    end

    assign bus.grant   = grant_r;
    assign bus.tx_data = tx_data_r;
    assign bus.tx_send = tx_send_r;
    assign bus.req_ack = req_ack_r;
    assign bus.active  = active_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester lane queues, an xmit busy model and a
// scoreboard of expected {lane, byte} in send order.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    typedef struct packed { logic [1:0] lane; logic [7:0] d; } sb_t;
    typedef struct packed { logic [7:0] d; logic lk; } lb_t;
    typedef struct {
        logic [3:0] mask;
        logic [7:0] order;   // 2 bits per grant, first grant in [1:0]
        int         n;
        logic [1:0] exp_ptr;
    } vec_t;

    localparam int BUSY_LEN = 10;

    logic clk;
    logic reset;
    uart_tx_arbiter_if #(.N(4)) bus ();

    uart_tx_arbiter #(.N(4), .START_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_tests;
    int   n_fail;
    sb_t  exp_q[$];
    lb_t  lq[4][$];
    int   gaps[$];
    int   sends[$];
    logic [3:0] drop_lock;
    logic no_busy;
    vec_t tbl[6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int lane, input logic [7:0] d, input logic lk);
        lq[lane].push_back('{d: d, lk: lk});
    endtask

    task automatic expect_byte(input int lane, input logic [7:0] d);
        exp_q.push_back('{lane: 2'(lane), d: d});
    endtask

    function automatic logic lanes_empty();
        return (lq[0].size() == 0) && (lq[1].size() == 0) &&
               (lq[2].size() == 0) && (lq[3].size() == 0);
    endfunction

    task automatic wait_done(input string name);
        int t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(exp_q.size() == 0 && bus.active == 1'b0 && lanes_empty()) && t < 2000);
        if (t >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes pending, want 0", name, exp_q.size());
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        int t = 0;
        while (dut.state_r !== st && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 32'(dut.state_r), 32'(st));
    endtask

    // Monitor, xmit busy model and requesters, evaluated in that order each negedge
    initial begin
        int   cyc = 0;
        int   fall_cyc = 0;
        int   busy_cnt = 0;
        logic pending = 1'b0;
        logic prev_send = 1'b0;
        logic [3:0] lock_v = 4'b0000;
        sb_t  e;
        lb_t  p;
        bus.req = 4'b0000;
        bus.req_data = 32'h0;
        bus.req_lock = 4'b0000;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tx_send === 1'b1) begin
                check("send_while_busy", 32'(bus.tx_busy), 32'd0);
                check("send_back_to_back", 32'(prev_send), 32'd0);
                check("ack_eq_grant", 32'(bus.req_ack), 32'(bus.grant));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_ack", 32'(bus.req_ack), 32'(4'b0001 << e.lane));
                    check("sb_data", 32'(bus.tx_data), 32'(e.d));
                end else begin
                    check("sb_unexpected_send", 32'(exp_q.size()), 32'd1);
                end
                gaps.push_back(cyc - fall_cyc);
                sends.push_back(cyc);
            end
            prev_send = bus.tx_send;
            if (reset) begin
                bus.tx_busy = 1'b0;
                busy_cnt = 0;
                pending = 1'b0;
                prev_send = 1'b0;
            end else if (pending) begin
                bus.tx_busy = 1'b1;
                busy_cnt = BUSY_LEN;
                pending = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bus.tx_busy = 1'b0;
                    fall_cyc = cyc;
                end
            end
            if (bus.tx_send === 1'b1 && !no_busy && !reset) pending = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (bus.req_ack[i] === 1'b1 && lq[i].size() > 0) begin
                    p = lq[i].pop_front();
                    lock_v[i] = p.lk;
                end
                if (lq[i].size() > 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[8*i +: 8] = lq[i][0].d;
                end else begin
                    bus.req[i] = 1'b0;
                end
                bus.req_lock[i] = lock_v[i] & ~drop_lock[i];
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        drop_lock = 4'b0000;
        no_busy = 1'b0;
        reset = 1'b1;

        tbl[0] = '{4'b1111, {2'd2, 2'd1, 2'd0, 2'd3}, 4, 2'd3};
        tbl[1] = '{4'b0101, {2'd0, 2'd0, 2'd2, 2'd0}, 2, 2'd3};
        tbl[2] = '{4'b0011, {2'd0, 2'd0, 2'd1, 2'd0}, 2, 2'd2};
        tbl[3] = '{4'b1001, {2'd0, 2'd0, 2'd0, 2'd3}, 2, 2'd1};
        tbl[4] = '{4'b0001, {2'd0, 2'd0, 2'd0, 2'd0}, 1, 2'd1};
        tbl[5] = '{4'b1110, {2'd0, 2'd3, 2'd2, 2'd1}, 3, 2'd0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_send", 32'(bus.tx_send), 32'd0);
        check("rst_req_ack", 32'(bus.req_ack), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single byte: send and ack in the cycle after the request
        drive(2, 8'h41, 1'b0);
        expect_byte(2, 8'h41);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("single_send_t1", 32'(bus.tx_send), 32'd1);
        check("single_ack_t1", 32'(bus.req_ack), 32'(4'b0100));
        check("single_data_t1", 32'(bus.tx_data), 32'h41);
        wait_done("single");
        check("single_ptr", 32'(dut.ptr_r), 32'd3);

        // Table: simultaneous requests, round-robin order from the carried ptr
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                if (tbl[v].mask[i]) drive(i, 8'(v * 16 + i), 1'b0);
            end
            for (int k = 0; k < tbl[v].n; k++) begin
                expect_byte(int'(tbl[v].order[2*k +: 2]), 8'(v * 16 + int'(tbl[v].order[2*k +: 2])));
            end
            wait_done("table");
            check("table_ptr", 32'(dut.ptr_r), 32'(tbl[v].exp_ptr));
        end

        // Fairness: every lane continuously requesting, two bytes each
        for (int i = 0; i < 4; i++) begin
            drive(i, 8'(8'h80 + i), 1'b0);
            drive(i, 8'(8'h90 + i), 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) expect_byte(i, 8'(8'h80 + 16 * k + i));
        end
        wait_done("fair");
        check("fair_ptr", 32'(dut.ptr_r), 32'd0);

        // Locked message on lane 1 with lane 0 pending behind it
        gaps.delete();
        drive(1, 8'h48, 1'b1);
        drive(1, 8'h49, 1'b1);
        drive(1, 8'h0A, 1'b0);
        expect_byte(1, 8'h48);
        expect_byte(1, 8'h49);
        expect_byte(1, 8'h0A);
        expect_byte(0, 8'h7A);
        begin
            int t = 0;
            while (exp_q.size() > 3 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
        end
        drive(0, 8'h7A, 1'b0);
        wait_done("lock");
        check("lock_ptr", 32'(dut.ptr_r), 32'd1);
        check("lock_gap_count", 32'(gaps.size()), 32'd4);
        if (gaps.size() == 4) begin
            check("lock_gap_b2b_1", 32'(gaps[1]), 32'd1);
            check("lock_gap_b2b_2", 32'(gaps[2]), 32'd1);
            check("unlock_gap", 32'(gaps[3]), 32'd2);
        end

        // Reset in WAIT_DONE clears everything asynchronously
        drive(1, 8'hC3, 1'b0);
        expect_byte(1, 8'hC3);
        begin
            int t = 0;
            while (bus.tx_busy !== 1'b1 && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("rst_mid_state", 32'(dut.state_r), 32'(ST_WAIT_DONE));
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_tx_send", 32'(bus.tx_send), 32'd0);
        check("rst_mid_req_ack", 32'(bus.req_ack), 32'd0);
        check("rst_mid_grant", 32'(bus.grant), 32'd0);
        check("rst_mid_active", 32'(bus.active), 32'd0);
        check("rst_mid_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_mid_ptr", 32'(dut.ptr_r), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(3, 8'h33, 1'b0);
        drive(0, 8'h11, 1'b0);
        expect_byte(0, 8'h11);
        expect_byte(3, 8'h33);
        wait_done("rst_after");
        check("rst_after_ptr", 32'(dut.ptr_r), 32'd0);

        // HOLD: lane 3 keeps the grant while idle, lane 0 must wait
        drive(3, 8'hA5, 1'b1);
        expect_byte(3, 8'hA5);
        wait_state(ST_HOLD, "hold_enter");
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_grant", 32'(bus.grant), 32'(4'b1000));
            check("hold_no_send", 32'(bus.tx_send), 32'd0);
        end
        drive(0, 8'h77, 1'b0);
        expect_byte(3, 8'h5A);
        expect_byte(0, 8'h77);
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_grant_pending", 32'(bus.grant), 32'(4'b1000));
        end
        drive(3, 8'h5A, 1'b0);
        wait_done("hold");
        check("hold_ptr", 32'(dut.ptr_r), 32'd1);

        // HOLD with lock dropped releases to IDLE
        drive(3, 8'h3C, 1'b1);
        expect_byte(3, 8'h3C);
        wait_state(ST_HOLD, "hold2_enter");
        drop_lock = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        check("hold_drop_grant", 32'(bus.grant), 32'd0);
        check("hold_drop_active", 32'(bus.active), 32'd0);
        check("hold_drop_ptr", 32'(dut.ptr_r), 32'd0);

        // Start timeout: xmit never goes busy, locked pair on lane 2
        no_busy = 1'b1;
        sends.delete();
        drive(2, 8'hE1, 1'b1);
        drive(2, 8'hE2, 1'b0);
        expect_byte(2, 8'hE1);
        expect_byte(2, 8'hE2);
        wait_done("timeout");
        check("timeout_sends", 32'(sends.size()), 32'd2);
        if (sends.size() == 2) check("timeout_spacing", 32'(sends[1] - sends[0]), 32'd6);
        check("timeout_ptr", 32'(dut.ptr_r), 32'd3);
        no_busy = 1'b0;

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
